// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, tag width, response metadata and flag helpers.
package alu_pkg;

  localparam int unsigned TAG_W  = 8;
  localparam int unsigned META_W = TAG_W + 2;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } rsp_state_e;

  // Per-response sideband carried next to the result word.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             carry;
  } rsp_meta_t;

  // Empty-queue head: result 0, so the zero flag reads as set.
  localparam rsp_meta_t META_RST = '{tag: '0, zero: 1'b1, carry: 1'b0};

  function automatic rsp_meta_t make_meta(input logic [TAG_W-1:0] tag,
                                          input logic             zero,
                                          input logic             carry);
    rsp_meta_t m;
    m.tag   = tag;
    m.zero  = zero;
    m.carry = carry;
    return m;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Circular response queue; head is the oldest entry, held until popped.
module alu_rsp_fifo #(
  parameter int unsigned       DATA_W  = 74,
  parameter int unsigned       DEPTH   = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; reset puts a benign value at every slot so the head reads clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: RST_VAL};
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_responder.sv
// Request/response ALU front end: single-cycle ops, shift-add multiply, response queue.
module alu_responder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             busy
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned STP_W = $clog2(WIDTH);
  localparam int unsigned PAY_W = WIDTH + META_W;
  localparam logic [PAY_W-1:0] PAY_RST = {{WIDTH{1'b0}}, META_RST};

  rsp_state_e       state;
  rsp_state_e       state_next;
  alu_op_e          op;
  logic             accept;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SH_W-1:0]  shamt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mul_sum;
  logic [STP_W-1:0] step;
  logic [TAG_W-1:0] mul_tag;
  logic             mul_last;

  logic             push;
  logic [PAY_W-1:0] push_data;
  logic [PAY_W-1:0] head;
  rsp_meta_t        head_meta;
  logic             fifo_full;

  assign op       = alu_op_e'(req_op);
  assign accept   = req_valid && req_ready;
  assign sum_ext  = {1'b0, req_a} + {1'b0, req_b};
  assign diff_ext = {1'b0, req_a} - {1'b0, req_b};
  assign shamt    = req_b[SH_W-1:0];
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (step == STP_W'(WIDTH - 1));

  // Single-cycle operators; carry is the ADD carry-out or the SUB no-borrow flag.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_AND:  alu_res = req_a & req_b;
      OP_OR:   alu_res = req_a | req_b;
      OP_XOR:  alu_res = req_a ^ req_b;
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = ~diff_ext[WIDTH];
      end
      OP_SLL:  alu_res = req_a << shamt;
      OP_SRL:  alu_res = req_a >> shamt;
      default: alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: a multiply holds the block until its last step.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && (op == OP_MUL)) state_next = ST_MUL;
      ST_MUL:  if (mul_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: handshake, busy and the queue push for whichever path finishes.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    push      = 1'b0;
    push_data = PAY_RST;
    case (state)
      ST_IDLE: begin
        req_ready = !fifo_full;
        push      = req_valid && !fifo_full && (op != OP_MUL);
        push_data = {alu_res, make_meta(req_tag, alu_res == '0, alu_carry)};
      end
      ST_MUL: begin
        busy      = 1'b1;
        push      = mul_last;
        push_data = {mul_sum, make_meta(mul_tag, mul_sum == '0, 1'b0)};
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Shift-add multiplier: one multiplier bit per cycle, product kept modulo 2^WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      step    <= '0;
      mul_tag <= '0;
    end else if ((state == ST_IDLE) && accept && (op == OP_MUL)) begin
      mcand   <= req_a;
      mplier  <= req_b;
      acc     <= '0;
      step    <= '0;
      mul_tag <= req_tag;
    end else if (state == ST_MUL) begin
      acc    <= mul_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + STP_W'(1);
    end
  end

  alu_rsp_fifo #(
    .DATA_W  (PAY_W),
    .DEPTH   (DEPTH),
    .RST_VAL (PAY_RST)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_ready),
    .head      (head),
    .valid     (rsp_valid),
    .full      (fifo_full)
  );

  assign rsp_result = head[PAY_W-1:META_W];
  assign head_meta  = head[META_W-1:0];
  assign rsp_tag    = head_meta.tag;
  assign rsp_zero   = head_meta.zero;
  assign rsp_carry  = head_meta.carry;

endmodule
